// File: rtl/datapath_ctrl.sv
// datapath_ctrl: push-button sequencer driving the 4-bit register/ALU/shift datapath.
// Define DATAPATH_CTRL_DEBOUNCE_EN to insert a DEB_CYCLES debouncer behind each button synchronizer.
module datapath_ctrl #(
   parameter int OP_W          = 3,
   parameter int SH_W          = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int DEB_CYCLES    = 50000
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            start,
   input  logic            next,
   input  logic [OP_W-1:0] op_sw,
   input  logic [SH_W-1:0] sh_sw,
   input  logic            sel_sw,
   output logic            ena,
   output logic            enb,
   output logic            enc,
   output logic            enshift,
   output logic [OP_W-1:0] op,
   output logic [SH_W-1:0] shmode,
   output logic            selectMux,
   output logic            busy,
   output logic            done,
   output logic [2:0]      state_dbg
);

   typedef enum logic [2:0] {
      st_idle    = 3'd0,
      st_load_a  = 3'd1,
      st_wait_b  = 3'd2,
      st_load_b  = 3'd3,
      st_exec    = 3'd4,
      st_shift   = 3'd5,
      st_store_c = 3'd6,
      st_done    = 3'd7
   } state_t;

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || DEB_CYCLES < 1) begin : g_bad_params
      $error("datapath_ctrl: SETTLE_CYCLES must be 1..15 and DEB_CYCLES at least 1");
   end

   logic [1:0] start_sync, next_sync;
   logic       start_lvl, next_lvl;
   logic       start_prev, next_prev;
   logic       start_edge, next_edge;

   // NOTE: sequential state uses <= so every flop samples pre-edge values, modelling real registers.
   always_ff @(posedge clock) begin
      if (!rst) begin
         start_sync <= '0;
         next_sync  <= '0;
      end else begin
         start_sync <= {start_sync[0], start};
         next_sync  <= {next_sync[0], next};
      end
   end

`ifdef DATAPATH_CTRL_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);

   logic [DEB_W-1:0] start_cnt, next_cnt;

   // The accepted level flips on the DEB_CYCLES-th consecutive disagreeing sample.
   always_ff @(posedge clock) begin
      if (!rst) begin
         start_cnt <= '0;
         next_cnt  <= '0;
         start_lvl <= 1'b0;
         next_lvl  <= 1'b0;
      end else begin
         if (start_sync[1] == start_lvl) begin
            start_cnt <= '0;
         end else if (start_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            start_cnt <= '0;
            start_lvl <= start_sync[1];
         end else begin
            start_cnt <= start_cnt + 1'b1;
         end
         if (next_sync[1] == next_lvl) begin
            next_cnt <= '0;
         end else if (next_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            next_cnt <= '0;
            next_lvl <= next_sync[1];
         end else begin
            next_cnt <= next_cnt + 1'b1;
         end
      end
   end
`else
   assign start_lvl = start_sync[1];
   assign next_lvl  = next_sync[1];
`endif

   always_ff @(posedge clock) begin
      if (!rst) begin
         start_prev <= 1'b0;
         next_prev  <= 1'b0;
      end else begin
         start_prev <= start_lvl;
         next_prev  <= next_lvl;
      end
   end

   assign start_edge = start_lvl & ~start_prev;
   assign next_edge  = next_lvl & ~next_prev;

   state_t     state, state_n;
   logic [3:0] settle_cnt;

   // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_n = state;
      if (start_edge) begin
         state_n = st_load_a;
      end else begin
         case (state)
            st_idle:    state_n = st_idle;
            st_load_a:  state_n = st_wait_b;
            st_wait_b:  if (next_edge) state_n = st_load_b;
            st_load_b:  state_n = st_exec;
            st_exec:    if (settle_cnt == 4'd0) state_n = st_shift;
            st_shift:   state_n = st_store_c;
            st_store_c: state_n = st_done;
            st_done:    state_n = st_done;
            default:    state_n = st_idle;
         endcase
      end
   end

   // Outputs are decoded from state_n so each pulse is a flop aligned with its state.
   always_ff @(posedge clock) begin
      if (!rst) begin
         state      <= st_idle;
         settle_cnt <= '0;
         ena        <= 1'b0;
         enb        <= 1'b0;
         enc        <= 1'b0;
         enshift    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         op         <= '0;
         shmode     <= '0;
         selectMux  <= 1'b0;
      end else begin
         state   <= state_n;
         ena     <= (state_n == st_load_a);
         enb     <= (state_n == st_load_b);
         enc     <= (state_n == st_store_c);
         enshift <= (state_n == st_shift);
         busy    <= (state_n != st_idle) && (state_n != st_done);
         done    <= (state_n == st_done);
         if (state == st_load_b) begin
            op         <= op_sw;
            shmode     <= sh_sw;
            selectMux  <= sel_sw;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
         end else if (state == st_exec && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed and randomized stimulus for datapath_ctrl, checked against a
// cycle-level reference model built from the operating rules (button latency, sequence, abort).
module tb_datapath_ctrl;

   localparam int SETTLE = 2;
   localparam int DEB    = 8;

   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       next = 1'b0;
   logic [2:0] op_sw = '0;
   logic [1:0] sh_sw = '0;
   logic       sel_sw = 1'b0;
   logic       ena, enb, enc, enshift;
   logic [2:0] op;
   logic [1:0] shmode;
   logic       selectMux, busy, done;
   logic [2:0] state_dbg;

   int vectors = 0;
   int miscompares = 0;

   datapath_ctrl #(
      .OP_W(3), .SH_W(2), .SETTLE_CYCLES(SETTLE), .DEB_CYCLES(DEB)
   ) dut (
      .clock(clock), .rst(rst), .start(start), .next(next),
      .op_sw(op_sw), .sh_sw(sh_sw), .sel_sw(sel_sw),
      .ena(ena), .enb(enb), .enc(enc), .enshift(enshift),
      .op(op), .shmode(shmode), .selectMux(selectMux),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   // Reference model: button histories (newest sample in bit 0) and sequence position.
   logic [3:0] hs = '0, hn = '0;
   logic [2:0] m_st = '0;
   int         m_exec = 0;
   logic [2:0] m_op = '0;
   logic [1:0] m_sh = '0;
   logic       m_sel = 1'b0;

   task automatic model_edge(input logic r, input logic s, input logic n,
                             input logic [2:0] o, input logic [1:0] sh, input logic sl);
      logic se, ne;
      logic [2:0] nxt;
      if (!r) begin
         m_st = 3'd0; m_exec = 0; m_op = '0; m_sh = '0; m_sel = 1'b0; hs = '0; hn = '0;
         return;
      end
      hs = {hs[2:0], s};
      hn = {hn[2:0], n};
      // A press first sampled two edges ago acts now, provided it was low before that.
      se = hs[2] & ~hs[3];
      ne = hn[2] & ~hn[3];
      if (m_st == 3'd3) begin
         m_op = o; m_sh = sh; m_sel = sl;
      end
      nxt = m_st;
      if (se) nxt = 3'd1;
      else if (m_st == 3'd1) nxt = 3'd2;
      else if (m_st == 3'd2 && ne) nxt = 3'd3;
      else if (m_st == 3'd3) nxt = 3'd4;
      else if (m_st == 3'd4 && m_exec >= SETTLE) nxt = 3'd5;
      else if (m_st == 3'd5) nxt = 3'd6;
      else if (m_st == 3'd6) nxt = 3'd7;
      if (nxt == 3'd4) m_exec = (m_st == 3'd4) ? m_exec + 1 : 1;
      m_st = nxt;
   endtask

   function automatic logic [31:0] model_out();
      return {17'd0, m_st == 3'd1, m_st == 3'd3, m_st == 3'd6, m_st == 3'd5, m_op, m_sh, m_sel,
              (m_st != 3'd0 && m_st != 3'd7), m_st == 3'd7, m_st};
   endfunction

   function automatic logic [31:0] dut_out();
      return {17'd0, ena, enb, enc, enshift, op, shmode, selectMux, busy, done, state_dbg};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: the model follows the inputs sampled at the rising edge, outputs are checked at the falling edge.
   task automatic cycle(input string tag);
      @(posedge clock);
`ifndef DATAPATH_CTRL_DEBOUNCE_EN
      model_edge(rst, start, next, op_sw, sh_sw, sel_sw);
`endif
      @(negedge clock);
`ifndef DATAPATH_CTRL_DEBOUNCE_EN
      check(tag, dut_out(), model_out());
`endif
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic pulse_next(input string tag);
      next = 1'b1; cycle(tag); next = 1'b0;
   endtask

   task automatic pulse_start(input string tag);
      start = 1'b1; cycle(tag); start = 1'b0;
   endtask

   initial begin
      int cnt;
      int first;
      @(negedge clock);

      // Reset with start held high; exactly one start edge after release.
      rst = 1'b0; start = 1'b1;
      run(2, "reset");
      check("reset_outputs", dut_out(), 32'd0);
      rst = 1'b1;

`ifndef DATAPATH_CTRL_DEBOUNCE_EN
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle("held_start");
         if (ena) cnt++;
      end
      check("held_start_ena_count", cnt, 1);
      start = 1'b0;

      // Full sequence with fixed switches; switches scrambled after capture.
      op_sw = 3'b010; sh_sw = 2'b01; sel_sw = 1'b1;
      run(3, "wait_b");
      check("wait_b_state", state_dbg, 3'd2);
      pulse_next("full_seq");
      run(4, "full_seq");
      op_sw = 3'($urandom); sh_sw = 2'($urandom); sel_sw = 1'($urandom);
      run(8, "full_seq");
      check("done_hold", {done, op, shmode, selectMux}, {1'b1, 3'd2, 2'd1, 1'b1});

      // next ignored in DONE.
      pulse_next("next_in_done");
      run(6, "next_in_done");

      // Abort in EXEC: start edge lands two cycles after the next edge.
      pulse_start("restart");
      run(4, "restart");
      op_sw = 3'($urandom); sh_sw = 2'($urandom); sel_sw = 1'($urandom);
      pulse_next("abort");
      cycle("abort");
      cnt = 0;
      pulse_start("abort");
      if (enc) cnt++;
      for (int i = 0; i < 12; i++) begin
         cycle("abort");
         if (enc) cnt++;
      end
      check("abort_no_enc", cnt, 0);
      check("abort_back_to_wait_b", state_dbg, 3'd2);

      // Simultaneous start and next in WAIT_B: start wins.
      start = 1'b1; next = 1'b1; cycle("start_and_next");
      start = 1'b0; next = 1'b0;
      run(2, "start_and_next");
      check("start_wins", {ena, state_dbg}, {1'b1, 3'd1});
      run(2, "start_and_next");

      // Reset during SHIFT.
      op_sw = 3'($urandom) | 3'd1; sh_sw = 2'($urandom); sel_sw = 1'($urandom);
      pulse_next("to_shift");
      for (int i = 0; i < 20 && state_dbg != 3'd5; i++) cycle("to_shift");
      check("reached_shift", {enshift, state_dbg}, {1'b1, 3'd5});
      rst = 1'b0; cycle("reset_mid_run"); rst = 1'b1;
      check("reset_mid_run", {enshift, op, state_dbg}, 7'd0);

      // next ignored in IDLE.
      pulse_next("next_in_idle");
      run(6, "next_in_idle");
      check("idle_after_next", state_dbg, 3'd0);

      // Randomized buttons, switches and occasional reset.
      for (int i = 0; i < 800; i++) begin
         start  = ($urandom_range(0, 15) == 0);
         next   = ($urandom_range(0, 5) == 0);
         op_sw  = 3'($urandom);
         sh_sw  = 2'($urandom);
         sel_sw = 1'($urandom);
         rst    = ($urandom_range(0, 149) != 0);
         cycle("random");
      end
`else
      // Debounce build: short bounces rejected, stable press accepted after 3 + DEB cycles.
      start = 1'b0;
      run(4, "deb_idle");
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         start = ((i / 3) % 2 == 0);
         cycle("deb_bounce");
         if (ena) cnt++;
      end
      start = 1'b0;
      check("deb_bounce_no_ena", cnt, 0);
      check("deb_bounce_idle", state_dbg, 3'd0);
      run(12, "deb_quiet");
      start = 1'b1;
      cnt = 0; first = -1;
      for (int k = 1; k <= 40; k++) begin
         cycle("deb_press");
         if (ena) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      start = 1'b0;
      check("deb_ena_latency", first, 3 + DEB);
      check("deb_ena_count", cnt, 1);
      check("deb_state", state_dbg, 3'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
